mux_4_1: RTL and testbench

//  Registered 4-to-1 selector. Picks one of four WIDTH-bit data inputs using a
//  2-bit select split across S1 (MSB) and S2 (LSB). Drives the result on a

---
 rtl/mux_pkg.sv | 9 +
 rtl/mux4_core.sv | 31 +++
 rtl/mux_4_1.sv | 47 ++++
 tb/tb_mux_4_1.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encodings for the registered 4:1 selector.
package mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// Combinational WIDTH-bit 4:1 selector, select = {S1, S2}.
module mux4_core
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic             S1,
    input  logic             S2,
    output logic [WIDTH-1:0] Y
);

    logic [1:0] sel;

    assign sel = {S1, S2};

    // The four codes cover every 2-bit value, so there is no fallback arm.
    always_comb begin
        Y = A;
        case (sel)
            SEL_A: Y = A;
            SEL_B: Y = B;
            SEL_C: Y = C;
            SEL_D: Y = D;
        endcase
    end

endmodule

// File: rtl/mux_4_1.sv
// Registered 4:1 selector: zero-latency F_comb plus F/out_valid one clock later.
module mux_4_1
    import mux_pkg::*;
#(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic             S1,
    input  logic             S2,
    output logic [WIDTH-1:0] F,
    output logic             out_valid,
    output logic [WIDTH-1:0] F_comb
);

    mux4_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .S1(S1),
        .S2(S2),
        .Y (F_comb)
    );

    // F holds across idle cycles; out_valid only marks freshly captured data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F         <= RESET_VAL;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                F <= F_comb;
            end
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_mux_4_1.sv
// Directed bench for mux_4_1: 1-bit and 8-bit instances share clock, reset and selects.
module tb_mux_4_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       S1;
    logic       S2;

    logic       a1, b1, c1, d1;
    logic       f1, ov1, fc1;

    logic [7:0] a8, b8, c8, d8;
    logic [7:0] f8, fc8;
    logic       ov8;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mux_4_1 #(
        .WIDTH(1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (a1),
        .B        (b1),
        .C        (c1),
        .D        (d1),
        .S1       (S1),
        .S2       (S2),
        .F        (f1),
        .out_valid(ov1),
        .F_comb   (fc1)
    );

    mux_4_1 #(
        .WIDTH    (8),
        .RESET_VAL(8'hA5)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (a8),
        .B        (b8),
        .C        (c8),
        .D        (d8),
        .S1       (S1),
        .S2       (S2),
        .F        (f8),
        .out_valid(ov8),
        .F_comb   (fc8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // An unknown select on a valid cycle is a stimulus error.
    always @(posedge clk) begin
        if (in_valid === 1'b1 && $isunknown({S1, S2})) begin
            n_errors++;
            $display("FAIL sel_unknown: got %b%b, expected known select", S1, S2);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp8 [4];
        logic [1:0] sel;
        exp8[0] = 8'h11;
        exp8[1] = 8'h22;
        exp8[2] = 8'h33;
        exp8[3] = 8'h44;

        // Reset held with valid data presented
        rst_n = 1'b0; in_valid = 1'b1; S1 = 1'b0; S2 = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
        step();
        step();
        check("rst_f1",   {7'd0, f1},  8'h00);
        check("rst_ov1",  {7'd0, ov1}, 8'h00);
        check("rst_f8",   f8,          8'hA5);
        check("rst_ov8",  {7'd0, ov8}, 8'h00);

        // Single capture, select C
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b1;
        S1 = 1'b1; S2 = 1'b0; in_valid = 1'b1;
        #1;
        check("t2_fcomb",  {7'd0, fc1}, 8'h01);
        check("t2_f_pre",  {7'd0, f1},  8'h00);
        step();
        check("t2_f",      {7'd0, f1},  8'h01);
        check("t2_ov",     {7'd0, ov1}, 8'h01);

        // Back-to-back sweep on both widths
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
        a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            S1 = sel[1]; S2 = sel[0];
            #1;
            check($sformatf("sweep_fc1_%0d", i), {7'd0, fc1}, (i == 0) ? 8'h01 : 8'h00);
            check($sformatf("sweep_fc8_%0d", i), fc8, exp8[i]);
            step();
            check($sformatf("sweep_f1_%0d", i),  {7'd0, f1},  (i == 0) ? 8'h01 : 8'h00);
            check($sformatf("sweep_f8_%0d", i),  f8, exp8[i]);
            check($sformatf("sweep_ov_%0d", i),  {7'd0, ov1}, 8'h01);
        end

        // Capture then hold with changed inputs
        S1 = 1'b0; S2 = 1'b0; in_valid = 1'b1;
        step();
        check("hold_cap_f1", {7'd0, f1}, 8'h01);
        in_valid = 1'b0; a1 = 1'b0; a8 = 8'h5A;
        #1;
        check("hold_fc1", {7'd0, fc1}, 8'h00);
        check("hold_fc8", fc8,         8'h5A);
        step();
        check("hold_f1",  {7'd0, f1},  8'h01);
        check("hold_ov1", {7'd0, ov1}, 8'h00);
        check("hold_f8",  f8,          8'h11);
        check("hold_ov8", {7'd0, ov8}, 8'h00);

        // Streaming interrupted by a one-cycle reset
        in_valid = 1'b1; S1 = 1'b1; S2 = 1'b1; d1 = 1'b1;
        step();
        check("strm_f1", {7'd0, f1},  8'h01);
        check("strm_f8", f8,          8'h44);
        rst_n = 1'b0; S1 = 1'b0; S2 = 1'b1; b1 = 1'b1;
        step();
        check("mid_rst_f1",  {7'd0, f1},  8'h00);
        check("mid_rst_ov1", {7'd0, ov1}, 8'h00);
        check("mid_rst_f8",  f8,          8'hA5);
        check("mid_rst_fc1", {7'd0, fc1}, 8'h01);
        check("mid_rst_fc8", fc8,         8'h22);
        rst_n = 1'b1; S1 = 1'b1; S2 = 1'b0; c1 = 1'b1;
        #1;
        check("resume_pre_f1", {7'd0, f1}, 8'h00);
        step();
        check("resume_f1",  {7'd0, f1},  8'h01);
        check("resume_ov1", {7'd0, ov1}, 8'h01);
        check("resume_f8",  f8,          8'h33);
        in_valid = 1'b0;
        step();
        check("idle_ov8", {7'd0, ov8}, 8'h00);
        check("idle_f8",  f8,          8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
